// File: rtl/instr_loader.sv
// instr_loader: packs field-level RV32I requests into 32-bit words and
// streams them into consecutive instruction-memory locations.
module instr_loader #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   CAP    = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [31:0]       enc;
  logic              legal;
  logic              accept;

  assign full      = (count_q == CAP);
  assign in_ready  = !full && !start;
  assign accept    = in_valid && in_ready;
  assign imem_we   = we_q;
  assign imem_addr = waddr_q;
  assign imem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;

  // Field packing per instruction class; classes 9..15 are flagged illegal.
  always_comb begin
    legal = 1'b1;
    enc   = '0;
    case (in_class)
      4'd0: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      4'd1: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      4'd2: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      4'd3: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      4'd4: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], 7'b1100011};
      4'd5: enc = {in_imm[31:12], in_rd, 7'b0110111};
      4'd6: enc = {in_imm[31:12], in_rd, 7'b0010111};
      4'd7: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      4'd8: enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      default: legal = 1'b0;
    endcase
  end

  // Next-state: start flushes everything; a legal accept issues one write,
  // an illegal accept only raises the sticky error.
  always_comb begin
    ptr_d   = ptr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    count_d = count_q;
    err_d   = err_q;
    if (start) begin
      ptr_d   = BASE_A;
      waddr_d = BASE_A;
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      if (legal) begin
        we_d    = 1'b1;
        waddr_d = ptr_q;
        wdata_d = enc;
        ptr_d   = ptr_q + 1'b1;
        count_d = count_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers; reset drops any pending write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= BASE_A;
      waddr_q <= BASE_A;
      wdata_q <= '0;
      we_q    <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: expected words pushed on accept, popped on imem_we.
module tb_instr_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready;
  logic [3:0]    in_class;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full, err;

  instr_loader #(.ADDR_W(AW), .BASE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [AW-1:0] a; logic [31:0] w; } exp_t;
  exp_t          sb[$];
  logic [31:0]   cur_exp = '0;
  logic [AW-1:0] exp_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Push expected word when a legal request is handed over.
  always @(posedge clk) begin
    if (!rst) begin
      if (start) exp_addr = '0;
      else if (in_valid && in_ready && in_class <= 4'd8) begin
        sb.push_back('{exp_addr, cur_exp});
        exp_addr = exp_addr + 1'b1;
      end
    end
  end

  // Reset discards anything in flight.
  always @(posedge rst) begin
    sb.delete();
    exp_addr = '0;
  end

  // Pop and compare on every write strobe.
  always @(negedge clk) begin
    exp_t e;
    if (imem_we) begin
      if (sb.size() == 0) chk("spurious_we", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("addr", 32'(imem_addr), 32'(e.a));
        chk("wdata", imem_wdata, e.w);
      end
    end
  end

  task automatic send(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] ew, input int budget,
                      output bit acc);
    in_class = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; cur_exp = ew;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm, input logic [31:0] ew);
    bit acc;
    send(cls, rd, rs1, rs2, f3, f7, imm, ew, 20, acc);
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_we", 32'(imem_we), 32'd0);
    chk("start_cnt", 32'(count), 32'd0);
    chk("start_addr", 32'(imem_addr), 32'd0);
    chk("start_err", 32'(err), 32'd0);
  endtask

  initial begin
    bit acc;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // ADD x3,x1,x2
    req(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3);
    chk("add_we", 32'(imem_we), 32'd1);
    chk("add_cnt", 32'(count), 32'd1);
    idle(2);

    // ADDI then SW back-to-back
    pulse_start();
    req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093);
    req(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423);
    chk("sw_cnt", 32'(count), 32'd2);
    idle(2);

    // Control flow and upper-immediate
    pulse_start();
    req(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3);
    req(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF);
    req(4'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7);
    idle(2);

    // start with a request pending: start wins
    start = 1'b1; in_valid = 1'b1; in_class = 4'd1; cur_exp = 32'hDEADBEEF;
    @(negedge clk);
    chk("start_blocks_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    chk("start_flush_we", 32'(imem_we), 32'd0);
    chk("start_flush_cnt", 32'(count), 32'd0);

    // Fill capacity: 4 writes, fifth held
    for (int k = 1; k <= 4; k++)
      req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), (32'(k) << 20) | 32'h93);
    chk("full_we", 32'(imem_we), 32'd1);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_cnt", 32'(count), 32'd4);
    send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 6, acc);
    chk("fifth_held", 32'(acc), 32'd0);
    idle(2);
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    // Illegal class between two legal requests
    pulse_start();
    req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100093);
    req(4'd12, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0);
    req(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00200113);
    idle(2);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_cnt", 32'(count), 32'd2);
    chk("ill_addr", 32'(imem_addr), 32'd1);
    idle(3);
    chk("ill_err_sticky", 32'(err), 32'd1);
    pulse_start();

    // JALR (funct3 forced to 0), AUIPC, LOAD from BASE
    req(4'd8, 5'd1, 5'd2, 5'd0, 3'd7, 7'd0, 32'd4, 32'h004100E7);
    req(4'd6, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 32'h00001197);
    req(4'd2, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'hFFFFFFF8, 32'hFF82A203);
    idle(2);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // Reset right after an accept: the write must vanish
    pulse_start();
    in_class = 4'd1; in_rd = 5'd1; in_rs1 = '0; in_funct3 = '0; in_imm = 32'd7;
    cur_exp = 32'h00700093; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    rst = 1'b1;
    #2;
    chk("rst_mid_we", 32'(imem_we), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_we", 32'(imem_we), 32'd0);
    chk("rst2_addr", 32'(imem_addr), 32'd0);
    chk("rst2_wdata", imem_wdata, 32'd0);
    chk("rst2_cnt", 32'(count), 32'd0);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_ready", 32'(in_ready), 32'd1);
    idle(3);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
